// File: rtl/fc_layer.sv
// fc_layer: fully-connected MAC stage over N_IN activations into N_OUT saturated neuron results.
// Define ARGMAX_EN to add the cls/cls_vld argmax outputs.
module fc_layer #(
  parameter int N_IN = 128,
  parameter int N_OUT = 10,
  parameter int DATA_W = 18,
  parameter int W_W = 8,
  parameter int FRAC = 6,
  parameter logic [N_OUT*N_IN*W_W-1:0] W_ROM = '0,
  parameter logic [N_OUT*DATA_W-1:0] B_ROM = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic din_vld,
  output logic bsy,
  output logic signed [DATA_W-1:0] dout,
  output logic dout_vld,
  output logic [$clog2(N_OUT)-1:0] dout_idx,
  output logic tx_done
`ifdef ARGMAX_EN
  ,
  output logic [$clog2(N_OUT)-1:0] cls,
  output logic cls_vld
`endif
);
  localparam int ACC_W = DATA_W + W_W + $clog2(N_IN);
  localparam int RW = ACC_W + 1;
  localparam int IW = $clog2(N_IN);
  localparam int OW = $clog2(N_OUT);
  localparam int AW = $clog2(N_OUT*N_IN);
  localparam logic signed [RW-1:0] RMAX = RW'((1 <<< (DATA_W-1)) - 1);
  localparam logic signed [RW-1:0] RMIN = -RMAX - RW'(1);
  typedef enum logic [1:0] {ACC, MAC, OUT, DONE} state_t;
  state_t state;
  logic signed [W_W-1:0] w_mem [N_OUT*N_IN];
  logic signed [DATA_W-1:0] b_mem [N_OUT];
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [DATA_W-1:0] a_reg;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] o_cnt;
  logic [AW-1:0] w_addr;
  logic signed [ACC_W-1:0] prod;
  logic signed [RW-1:0] r;
  logic signed [DATA_W-1:0] sat;
  logic o_last;
  for (genvar k = 0; k < N_OUT*N_IN; k++) begin : g_w
    assign w_mem[k] = W_ROM[k*W_W +: W_W];
  end
  for (genvar k = 0; k < N_OUT; k++) begin : g_b
    assign b_mem[k] = B_ROM[k*DATA_W +: DATA_W];
  end
  assign bsy = state != ACC;
  assign o_last = o_cnt == OW'(N_OUT-1);
  assign w_addr = AW'(int'(o_cnt) * N_IN + int'(in_cnt));
  assign prod = ACC_W'(a_reg) * ACC_W'(w_mem[w_addr]);
  // extra headroom bit so bias add cannot overflow before saturation
  assign r = RW'(acc[o_cnt] >>> FRAC) + RW'(b_mem[o_cnt]);
  assign sat = r > RMAX ? DATA_W'(RMAX) : r < RMIN ? DATA_W'(RMIN) : r[DATA_W-1:0];
`ifdef ARGMAX_EN
  logic signed [DATA_W-1:0] max_val;
  logic [OW-1:0] max_idx;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      in_cnt <= '0;
      o_cnt <= '0;
      a_reg <= '0;
      dout <= '0;
      dout_vld <= 1'b0;
      dout_idx <= '0;
      tx_done <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
`ifdef ARGMAX_EN
      max_val <= '0;
      max_idx <= '0;
      cls <= '0;
      cls_vld <= 1'b0;
`endif
    end else begin
      dout_vld <= 1'b0;
      tx_done <= 1'b0;
`ifdef ARGMAX_EN
      cls_vld <= 1'b0;
`endif
      case (state)
        ACC: if (din_vld) begin
          a_reg <= din;
          o_cnt <= '0;
          state <= MAC;
        end
        MAC: begin
          acc[o_cnt] <= acc[o_cnt] + prod;
          o_cnt <= o_last ? '0 : o_cnt + 1'b1;
          if (o_last) begin
            in_cnt <= in_cnt == IW'(N_IN-1) ? '0 : in_cnt + 1'b1;
            state <= in_cnt == IW'(N_IN-1) ? OUT : ACC;
          end
        end
        OUT: begin
          dout <= sat;
          dout_vld <= 1'b1;
          dout_idx <= o_cnt;
          o_cnt <= o_last ? '0 : o_cnt + 1'b1;
          state <= o_last ? DONE : OUT;
`ifdef ARGMAX_EN
          if (o_cnt == '0 || sat > max_val) begin
            max_val <= sat;
            max_idx <= o_cnt;
          end
`endif
        end
        default: begin
          tx_done <= 1'b1;
          for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
          state <= ACC;
`ifdef ARGMAX_EN
          cls <= max_idx;
          cls_vld <= 1'b1;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: self-checking bench; several fc_layer instances with different ROM images share one input stream.
module tb_fc_layer;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int NC = 5;
  // neuron o, input i lives at byte o*NI+i
  localparam logic [63:0] W_CFG [NC] = '{
    64'hC0C0C0C0_40404040,
    64'hC0C0C0C0_40404040,
    64'h80808080_7F7F7F7F,
    64'h40404040_40404040,
    64'h7FA60B32_9C19F903
  };
  localparam logic [35:0] B_CFG [NC] = '{
    36'd0,
    {18'h3FFFD, 18'h00005},
    36'd0,
    36'd0,
    {18'd260144, 18'd1000}
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_vld = 1'b0;
  logic signed [17:0] din = '0;
  logic bsy_a [NC];
  logic signed [17:0] dout_a [NC];
  logic dout_vld_a [NC];
  logic [0:0] idx_a [NC];
  logic tx_a [NC];
`ifdef ARGMAX_EN
  logic [0:0] cls_a [NC];
  logic cv_a [NC];
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < NC; k++) begin : g
    fc_layer #(.N_IN(NI), .N_OUT(NO), .DATA_W(18), .W_W(8), .FRAC(6),
               .W_ROM(W_CFG[k]), .B_ROM(B_CFG[k])) u (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .bsy(bsy_a[k]),
      .dout(dout_a[k]), .dout_vld(dout_vld_a[k]), .dout_idx(idx_a[k]), .tx_done(tx_a[k])
`ifdef ARGMAX_EN
      , .cls(cls_a[k]), .cls_vld(cv_a[k])
`endif
    );
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // reference: exact integer dot product, floor divide by 2^FRAC, add bias, clamp
  function automatic int model(int k, int o, int d[NI]);
    longint acc = 0;
    longint r;
    logic signed [7:0] wv;
    logic signed [17:0] bv;
    for (int i = 0; i < NI; i++) begin
      wv = W_CFG[k][(o*NI+i)*8 +: 8];
      acc += longint'(d[i]) * longint'(wv);
    end
    bv = B_CFG[k][o*18 +: 18];
    r = (acc >= 0 ? acc / 64 : -((-acc + 63) / 64)) + longint'(bv);
    return r > 131071 ? 131071 : r < -131072 ? -131072 : int'(r);
  endfunction

  task automatic send(input int d[NI], input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      int gap = 0;
      while (bsy_a[0] === 1'b1 && gap < 40) begin
        din_vld = hold;
        din = 18'($urandom);
        step;
        gap++;
      end
      if (i > 0) begin
        checks++;
        if (gap != NO) begin
          errors++;
          $display("FAIL accept_gap input %0d: got %0d busy cycles, expected %0d", i, gap, NO);
        end
      end
      din = 18'(d[i]);
      din_vld = 1'b1;
      step;
    end
    din_vld = 1'b0;
  endtask

  task automatic collect(input int d[NI], input string name);
    int e [NC][NO];
    int seen [NC];
    int last [NC];
    bit done = 1'b0;
`ifdef ARGMAX_EN
    int ec [NC];
`endif
    for (int k = 0; k < NC; k++) begin
      seen[k] = 0;
      last[k] = 0;
      for (int o = 0; o < NO; o++) e[k][o] = model(k, o, d);
`ifdef ARGMAX_EN
      ec[k] = 0;
      for (int o = 1; o < NO; o++) if (e[k][o] > e[k][ec[k]]) ec[k] = o;
`endif
    end
    for (int s = 1; s <= 40 && !done; s++) begin
      step;
      for (int k = 0; k < NC; k++) begin
        if (dout_vld_a[k]) begin
          checks++;
          if (seen[k] >= NO) begin
            errors++;
            $display("FAIL %s dout extra cfg%0d: got idx %0d val %0d, expected no output", name, k, idx_a[k], dout_a[k]);
          end else if (idx_a[k] !== 1'(seen[k]) || dout_a[k] !== 18'(e[k][seen[k]]) ||
                       s != (seen[k] == 0 ? NO + 1 : last[k] + 1)) begin
            errors++;
            $display("FAIL %s dout cfg%0d n%0d: got idx %0d val %0d at step %0d, expected idx %0d val %0d at step %0d",
                     name, k, seen[k], idx_a[k], dout_a[k], s, seen[k], e[k][seen[k]],
                     seen[k] == 0 ? NO + 1 : last[k] + 1);
          end
          seen[k]++;
          last[k] = s;
        end
        if (tx_a[k]) begin
          checks++;
          if (seen[k] != NO || s != last[k] + 1) begin
            errors++;
            $display("FAIL %s tx_done cfg%0d: got at step %0d after %0d results, expected step %0d after %0d",
                     name, k, s, seen[k], last[k] + 1, NO);
          end
`ifdef ARGMAX_EN
          checks++;
          if (cv_a[k] !== 1'b1 || cls_a[k] !== 1'(ec[k])) begin
            errors++;
            $display("FAIL %s cls cfg%0d: got vld %0b cls %0d, expected vld 1 cls %0d", name, k, cv_a[k], cls_a[k], ec[k]);
          end
`endif
          if (k == 0) done = 1'b1;
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no tx_done within 40 cycles, expected one", name);
    end
  endtask

  task automatic run_frame(input int d[NI], input bit hold, input string name);
    send(d, NI, hold);
    collect(d, name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    din_vld = 1'b0;
    repeat (3) step;
    for (int k = 0; k < NC; k++) begin
      checks++;
      if ({dout_vld_a[k], tx_a[k], bsy_a[k]} !== 3'b000 || dout_a[k] !== 18'sd0 || idx_a[k] !== 1'b0
`ifdef ARGMAX_EN
          || cls_a[k] !== 1'b0 || cv_a[k] !== 1'b0
`endif
          ) begin
        errors++;
        $display("FAIL reset cfg%0d: got vld %0b tx %0b bsy %0b dout %0d idx %0d, expected all 0",
                 k, dout_vld_a[k], tx_a[k], bsy_a[k], dout_a[k], idx_a[k]);
      end
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic;
    int f [NI];
    f = '{10, 20, 30, 40};
    run_frame(f, 1'b0, "basic");
  endtask

  task automatic test_back_to_back;
    int f [NI];
    f = '{10, 20, 30, 40};
    run_frame(f, 1'b0, "b2b_a");
    run_frame(f, 1'b0, "b2b_b");
  endtask

  task automatic test_saturation;
    int f [NI];
    f = '{131071, 131071, 131071, 131071};
    run_frame(f, 1'b0, "sat_pos");
    f = '{-131072, -131072, -131072, -131072};
    run_frame(f, 1'b0, "sat_neg");
  endtask

  task automatic test_busy_hold;
    int f [NI];
    f = '{10, 20, 30, 40};
    run_frame(f, 1'b1, "busy_hold");
  endtask

  task automatic test_reset_mid_frame;
    int f [NI];
    f = '{70, -5, 900, 3};
    send(f, 2, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (bsy_a[k] !== 1'b0 || tx_a[k] !== 1'b0 || dout_vld_a[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset cfg%0d: got bsy %0b tx %0b vld %0b, expected 0 0 0", k, bsy_a[k], tx_a[k], dout_vld_a[k]);
      end
    end
    f = '{10, 20, 30, 40};
    run_frame(f, 1'b0, "after_reset");
  endtask

  task automatic test_argmax;
    int f [NI];
    f = '{-10, -20, -30, -40};
    run_frame(f, 1'b0, "argmax_neg");
    f = '{5, 10, 15, 20};
    run_frame(f, 1'b0, "argmax_tie");
  endtask

  task automatic test_random;
    int f [NI];
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NI; i++)
        f[i] = (n % 3 == 0) ? int'($urandom_range(0, 262143)) - 131072 : int'($urandom_range(0, 4000)) - 2000;
      run_frame(f, 1'($urandom_range(0, 1)), $sformatf("random%0d", n));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_saturation;
    test_busy_hold;
    test_reset_mid_frame;
    test_argmax;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
